i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
- Shares the single I2C `master` instance between NUM_REQ on-chip requesters (e.g. sensor poll, config writer, debug port).
- Arbitrates round-robin and drives the master's en/start/stop/mode/address/regist inputs with fixed cycle timing.
- Captures the master's data_out and returns it to the granted requester with a one-cycle done pulse.
- Sits between requester logic and `master`; sda/scl stay on the master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SETUP_CYCLES, 2, cycles address/regist/mode are held stable before start asserts (>=1).
- START_CYCLES, 40, cycles m_start held high, covering one full master transaction (>=1).
- STOP_CYCLES, 10, cycles m_stop held high before data capture (>=1).
- CNT_W, 8, phase counter width; must hold max(SETUP,START,STOP)_CYCLES.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  request per requester; level, held until its done.
- req_mode  in  NUM_REQ  per-requester mode bit forwarded to master (1 = read).
- req_addr  in  NUM_REQ*7  packed 7-bit slave addresses; requester i at [7i+6:7i].
- req_reg  in  NUM_REQ*8  packed 8-bit register/data bytes; requester i at [8i+7:8i].
- gnt  out  NUM_REQ  one-hot grant, high from SETUP through CAPTURE.
- done  out  NUM_REQ  one-cycle pulse to the granted requester at CAPTURE.
- rd_data  out  8  data captured from m_data_out; valid with done, held until next capture.
- m_en  out  1  master enable.
- m_start  out  1  master start.
- m_stop  out  1  master stop.
- m_mode  out  1  master mode.
- m_address  out  7  master slave address.
- m_regist  out  8  master register byte.
- m_data_out  in  8  master data_out.
- req_lock  in  NUM_REQ  only when I2C_ARB_LOCK_EN is defined.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - All outputs 0; state IDLE; rr pointer 0; counter 0.
  - Reset mid-transaction aborts immediately: m_start and m_stop drop on the same edge.
- m_en: 1 in every state once reset is released. It first rises one cycle after reset_n goes high.
- FSM states: IDLE, SETUP, START, STOP, CAPTURE.
- IDLE:
  - If any req bit is set, grant the first requester at or after rr pointer (wrapping modulo NUM_REQ). Go to SETUP.
  - Latch that requester's req_mode/req_addr/req_reg into m_mode/m_address/m_regist.
  - Set gnt one-hot; counter = 0.
- SETUP: hold latched fields; after SETUP_CYCLES cycles go to START.
- START: m_start=1 for exactly START_CYCLES cycles, then go to STOP.
- STOP:
  - m_start=0, m_stop=1 for exactly STOP_CYCLES cycles, then go to CAPTURE.
  - m_start and m_stop are never high together.
- CAPTURE (1 cycle):
  - m_stop=0; rd_data <= m_data_out (captured even for writes).
  - done[g]=1; rr pointer = (g+1) mod NUM_REQ.
  - Next state IDLE; gnt clears on leaving CAPTURE.
- Idle gap: minimum one IDLE cycle between transactions.
  - Total latency IDLE-grant to done = SETUP_CYCLES+START_CYCLES+STOP_CYCLES+1 cycles.
- Requester inputs may change during a transaction without effect; the latched fields are used.
- A req dropped mid-transaction does not abort it; done still pulses.
- Simultaneous requests: only the rr order decides; no starvation. Worst-case wait is NUM_REQ-1 transactions.
- req bits for indices >= NUM_REQ do not exist; the pointer wraps at NUM_REQ-1 to 0.

Optional Feature:
- Macro I2C_ARB_LOCK_EN.
- Defined:
  - Adds req_lock. If req_lock[g] is high in CAPTURE, the rr pointer stays at g instead of advancing.
  - If req[g] is still high in IDLE, g is re-granted, giving back-to-back transactions; lock releases when req_lock[g] falls.
- Undefined: port absent; strict round-robin.

Decomposition:
- Shared package i2c_pkg:
  - State encoding localparams (IDLE=0..CAPTURE=4).
  - I2C_ADDR_W=7, I2C_BYTE_W=8.
  - Default timing constants, reused by `master`/`slave` benches.
- One sub-module: i2c_rr_pick.
  - Combinational round-robin picker: req vector + pointer -> one-hot grant + index.
  - Unit-testable alone.

Test Plan:
- Single request: req=0001, addr 7'b1110000, reg 8'hF0, mode 1, defaults.
  - gnt=0001 next cycle; m_start high 40 cycles; m_stop high 10.
  - done[0] pulses 53 cycles after grant; rd_data = slave mess 8'h0F.
- All four requesting continuously: grants in order 0,1,2,3,0.
  - Each done pulse separated by 54 cycles.
- Requests 1 and 3 with pointer at 2: requester 3 is granted first, then 1.
- reset_n low during START: next edge m_start=0, gnt=0, done=0, m_en=0.
  - After release, the pending req restarts from SETUP with fresh latched fields.
- Change req_addr[0] during START: m_address stays at the value latched in IDLE.
- I2C_ARB_LOCK_EN, req=0011, req_lock=0001:
  - Requester 0 is granted twice back-to-back.
  - Drop req_lock and requester 1 is granted next.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction arbiter and the I2C master/slave benches.
// Contents: bus field widths, FSM state encoding, default timing constants and
// the packed command payload latched per transaction.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_BYTE_W = 8;

  // Arbiter FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_CAPTURE = 3'd4;

  // Default configuration and master timing
  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_SETUP_CYCLES = 2;
  localparam int unsigned DEF_START_CYCLES = 40;
  localparam int unsigned DEF_STOP_CYCLES  = 10;
  localparam int unsigned DEF_CNT_W        = 8;

  // Fields forwarded to the master for one transaction
  typedef struct packed {
    logic                  mode;
    logic [I2C_ADDR_W-1:0] addr;
    logic [I2C_BYTE_W-1:0] regist;
  } i2c_cmd_t;

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Requester and master-side signal bundle for i2c_txn_arbiter.
// Modport master: the arbiter (drives gnt/done/rd_data and the m_* controls).
// Modport slave : the environment (requesters plus the I2C master's data_out).
// req_lock exists only when I2C_ARB_LOCK_EN is defined.
interface i2c_txn_arbiter_if
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) ();

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_mode;
  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*I2C_BYTE_W-1:0] req_reg;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic [I2C_BYTE_W-1:0]         rd_data;
`ifdef I2C_ARB_LOCK_EN
  logic [NUM_REQ-1:0]            req_lock;
`endif

  logic                          m_en;
  logic                          m_start;
  logic                          m_stop;
  logic                          m_mode;
  logic [I2C_ADDR_W-1:0]         m_address;
  logic [I2C_BYTE_W-1:0]         m_regist;
  logic [I2C_BYTE_W-1:0]         m_data_out;

  modport master (
`ifdef I2C_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req, req_mode, req_addr, req_reg, m_data_out,
    output gnt, done, rd_data, m_en, m_start, m_stop, m_mode, m_address, m_regist
  );

  modport slave (
`ifdef I2C_ARB_LOCK_EN
    output req_lock,
`endif
    output req, req_mode, req_addr, req_reg, m_data_out,
    input  gnt, done, rd_data, m_en, m_start, m_stop, m_mode, m_address, m_regist
  );

endinterface

// File: rtl/i2c_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping at N.
// Ports: req_i   request vector
//        ptr_i   round-robin start index (0..N-1)
//        gnt_c_o one-hot grant (zero when no request)
//        idx_c_o index of the granted request
//        any_c_o at least one request is set
module i2c_rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_c_o,
  output logic [IDX_W-1:0] idx_c_o,
  output logic             any_c_o
);

  // Scan N positions starting at the pointer; the first hit wins
  always_comb begin
    logic found;
    gnt_c_o = '0;
    idx_c_o = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned pos;
      pos = (32'(ptr_i) + k) % N;
      if (!found && req_i[IDX_W'(pos)]) begin
        found                 = 1'b1;
        gnt_c_o[IDX_W'(pos)]  = 1'b1;
        idx_c_o               = IDX_W'(pos);
      end
    end
  end

  assign any_c_o = |req_i;

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master between NUM_REQ requesters.
// Drives the master's en/start/stop/mode/address/regist with fixed phase timing
// (SETUP -> START -> STOP -> CAPTURE) and returns the master's data_out to the
// granted requester with a one-cycle done pulse.
// Ports: clk, reset_n (synchronous, active-low)
//        bus (i2c_txn_arbiter_if.master): req/req_mode/req_addr/req_reg in,
//        gnt/done/rd_data out, m_en/m_start/m_stop/m_mode/m_address/m_regist out,
//        m_data_out in.
// Optional: define I2C_ARB_LOCK_EN to add req_lock, which holds the round-robin
// pointer on the current requester so it can be re-granted back-to-back.
module i2c_txn_arbiter
  import i2c_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int unsigned START_CYCLES = DEF_START_CYCLES,
  parameter int unsigned STOP_CYCLES  = DEF_STOP_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input logic               clk,
  input logic               reset_n,
  i2c_txn_arbiter_if.master bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      rr_q, rr_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [I2C_BYTE_W-1:0] rd_data_q, rd_data_d;
  logic                  m_en_q, m_en_d;
  logic                  m_start_q, m_start_d;
  logic                  m_stop_q, m_stop_d;
  i2c_cmd_t              cmd_q, cmd_d;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  i2c_cmd_t              sel_cmd;
  logic [IDX_W-1:0]      rr_adv;

  i2c_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (bus.req),
    .ptr_i   (rr_q),
    .gnt_c_o (pick_gnt),
    .idx_c_o (pick_idx),
    .any_c_o (pick_any)
  );

  // One-hot mux of the winning requester's packed fields
  always_comb begin
    sel_cmd = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_cmd.mode   = bus.req_mode[i];
        sel_cmd.addr   = bus.req_addr[i*I2C_ADDR_W +: I2C_ADDR_W];
        sel_cmd.regist = bus.req_reg[i*I2C_BYTE_W +: I2C_BYTE_W];
      end
    end
  end

  // Pointer to the requester after the current one, wrapping at NUM_REQ-1
  assign rr_adv = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    idx_d     = idx_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    rd_data_d = rd_data_q;
    m_en_d    = 1'b1;
    m_start_d = m_start_q;
    m_stop_d  = m_stop_q;
    cmd_d     = cmd_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_SETUP;
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          cmd_d   = sel_cmd;
          cnt_d   = '0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
          state_d   = ST_START;
          m_start_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_START: begin
        // start and stop hand over on the same edge, never overlapping
        if (cnt_q == CNT_W'(START_CYCLES - 1)) begin
          state_d   = ST_STOP;
          m_start_d = 1'b0;
          m_stop_d  = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_W'(STOP_CYCLES - 1)) begin
          state_d  = ST_CAPTURE;
          m_stop_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        state_d   = ST_IDLE;
        rd_data_d = bus.m_data_out;
        done_d    = gnt_q;
        gnt_d     = '0;
        rr_d      = rr_adv;
`ifdef I2C_ARB_LOCK_EN
        if (bus.req_lock[idx_q]) begin
          rr_d = idx_q;
        end
`endif
      end
      default: begin
        state_d   = ST_IDLE;
        gnt_d     = '0;
        m_start_d = 1'b0;
        m_stop_d  = 1'b0;
        cnt_d     = '0;
      end
    endcase
  end

  // State register; reset aborts any transaction on the same edge
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rr_q      <= '0;
      idx_q     <= '0;
      gnt_q     <= '0;
      done_q    <= '0;
      rd_data_q <= '0;
      m_en_q    <= 1'b0;
      m_start_q <= 1'b0;
      m_stop_q  <= 1'b0;
      cmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      idx_q     <= idx_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      m_en_q    <= m_en_d;
      m_start_q <= m_start_d;
      m_stop_q  <= m_stop_d;
      cmd_q     <= cmd_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.done      = done_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.m_en      = m_en_q;
  assign bus.m_start   = m_start_q;
  assign bus.m_stop    = m_stop_q;
  assign bus.m_mode    = cmd_q.mode;
  assign bus.m_address = cmd_q.addr;
  assign bus.m_regist  = cmd_q.regist;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: randomized requests and fields checked
// against a transaction-level round-robin model (pointer + latency arithmetic).
module tb_i2c_txn_arbiter;
  import i2c_pkg::*;

  localparam int N     = 4;
  localparam int SETUP = 2;
  localparam int START = 40;
  localparam int STOP  = 10;
  localparam int LAT   = SETUP + START + STOP + 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  i2c_txn_arbiter_if #(.NUM_REQ(N)) bus ();

  i2c_txn_arbiter #(
    .NUM_REQ(N), .SETUP_CYCLES(SETUP), .START_CYCLES(START),
    .STOP_CYCLES(STOP), .CNT_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master)
  );

  // Reference model state and requester fields
  int         model_ptr;
  logic [6:0] f_addr [N];
  logic [7:0] f_reg  [N];
  logic       f_mode [N];

  // Observations of one transaction
  logic [N-1:0] ft_gnt, ft_done, ft_gnt_after, ft_lock;
  logic         ft_mode, ft_mode_end;
  logic [6:0]   ft_addr, ft_addr_end;
  logic [7:0]   ft_reg, ft_reg_end, ft_rd;
  int           ft_wait, ft_sfirst, ft_slen, ft_plen, ft_done_c, ft_done_abs;
  bit           ft_overlap, ft_unstable, ft_timeout;

  function automatic int model_pick(logic [N-1:0] r, int ptr);
    for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic set_fields();
    for (int i = 0; i < N; i++) begin
      bus.req_addr[i*7 +: 7] = f_addr[i];
      bus.req_reg[i*8 +: 8]  = f_reg[i];
      bus.req_mode[i]        = f_mode[i];
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      f_addr[i] = 7'($urandom);
      f_reg[i]  = 8'($urandom);
      f_mode[i] = 1'($urandom);
    end
    set_fields();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.req = '0;
`ifdef I2C_ARB_LOCK_EN
    bus.req_lock = '0;
`endif
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    model_ptr = 0;
  endtask

  // Observe one transaction from grant to done; optionally disturb inputs at cycle mutate_c
  task automatic follow_txn(input int mutate_c);
    int c;
    ft_timeout = 0; ft_overlap = 0; ft_unstable = 0; ft_slen = 0; ft_plen = 0;
    ft_sfirst = -1; ft_done_c = -1; ft_done = '0; ft_wait = 0; ft_rd = '0;
    do begin
      @(negedge clk);
      ft_wait++;
    end while (bus.gnt === '0 && ft_wait < 200);
    ft_gnt = bus.gnt; ft_mode = bus.m_mode; ft_addr = bus.m_address; ft_reg = bus.m_regist;
    if (bus.gnt === '0) begin
      ft_timeout = 1;
      return;
    end
    c = 0;
    while (1) begin
      @(negedge clk);
      c++;
      if (c == mutate_c) begin
        bus.req_addr = ~bus.req_addr;
        bus.req_reg  = ~bus.req_reg;
        bus.req_mode = ~bus.req_mode;
        bus.req      = '0;
      end
      if (bus.m_start === 1'b1 && bus.m_stop === 1'b1) ft_overlap = 1;
      if (bus.m_start === 1'b1) begin
        if (ft_sfirst < 0) ft_sfirst = c;
        ft_slen++;
      end
      if (bus.m_stop === 1'b1) ft_plen++;
      if (bus.done !== '0) begin
        ft_done_c = c; ft_done = bus.done; ft_rd = bus.rd_data; ft_gnt_after = bus.gnt;
        ft_addr_end = bus.m_address; ft_reg_end = bus.m_regist; ft_mode_end = bus.m_mode;
        ft_done_abs = cyc;
`ifdef I2C_ARB_LOCK_EN
        ft_lock = bus.req_lock;
`else
        ft_lock = '0;
`endif
        break;
      end
      if (bus.gnt !== ft_gnt) ft_unstable = 1;
      if (c >= 200) begin
        ft_timeout = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.gnt, bus.done, bus.rd_data, bus.m_en, bus.m_start, bus.m_stop,
         bus.m_mode, bus.m_address, bus.m_regist} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b done=%b rd=%h en=%b start=%b stop=%b, all required 0",
               bus.gnt, bus.done, bus.rd_data, bus.m_en, bus.m_start, bus.m_stop);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.m_en !== 1'b1) begin
      errors++; $display("FAIL reset_m_en_rise: got %b required 1", bus.m_en);
    end
    checks++;
    if (bus.gnt !== '0) begin
      errors++; $display("FAIL reset_idle_gnt: got %b required 0", bus.gnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    rand_fields();
    f_addr[0] = 7'b1110000; f_reg[0] = 8'hF0; f_mode[0] = 1'b1;
    set_fields();
    bus.m_data_out = 8'h0F;
    bus.req = 4'b0001;
    follow_txn(-1);
    bus.req = '0;
    model_ptr = 1;
    checks++; if (ft_timeout) begin errors++; $display("FAIL single_timeout: got 1 required 0"); end
    checks++; if (ft_wait !== 1) begin errors++; $display("FAIL single_grant_delay: got %0d required 1", ft_wait); end
    checks++; if (ft_gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b required 0001", ft_gnt); end
    checks++; if (ft_addr !== 7'b1110000) begin errors++; $display("FAIL single_addr: got %h required 70", ft_addr); end
    checks++; if (ft_reg !== 8'hF0) begin errors++; $display("FAIL single_reg: got %h required f0", ft_reg); end
    checks++; if (ft_mode !== 1'b1) begin errors++; $display("FAIL single_mode: got %b required 1", ft_mode); end
    checks++; if (ft_sfirst !== SETUP) begin errors++; $display("FAIL single_start_rise: got %0d required %0d", ft_sfirst, SETUP); end
    checks++; if (ft_slen !== START) begin errors++; $display("FAIL single_start_len: got %0d required %0d", ft_slen, START); end
    checks++; if (ft_plen !== STOP) begin errors++; $display("FAIL single_stop_len: got %0d required %0d", ft_plen, STOP); end
    checks++; if (ft_overlap) begin errors++; $display("FAIL single_start_stop_overlap: got 1 required 0"); end
    checks++; if (ft_unstable) begin errors++; $display("FAIL single_gnt_stable: got 1 required 0"); end
    checks++; if (ft_done_c !== LAT) begin errors++; $display("FAIL single_done_latency: got %0d required %0d", ft_done_c, LAT); end
    checks++; if (ft_done !== 4'b0001) begin errors++; $display("FAIL single_done: got %b required 0001", ft_done); end
    checks++; if (ft_rd !== 8'h0F) begin errors++; $display("FAIL single_rd_data: got %h required 0f", ft_rd); end
    checks++; if (ft_gnt_after !== '0) begin errors++; $display("FAIL single_gnt_clear: got %b required 0", ft_gnt_after); end
    @(negedge clk);
    checks++; if (bus.done !== '0) begin errors++; $display("FAIL single_done_pulse: got %b required 0", bus.done); end
    checks++; if (bus.rd_data !== 8'h0F) begin errors++; $display("FAIL single_rd_hold: got %h required 0f", bus.rd_data); end
  endtask

  // Run a sequence of transactions; reqs[t] is the request vector presented before txn t
  task automatic run_seq(input string name, input logic [N-1:0] reqs [$], input bit chain);
    logic [N-1:0] exp_oh;
    logic [7:0]   d;
    int           exp, prev_abs;
    prev_abs = -1;
    for (int t = 0; t < reqs.size(); t++) begin
      bus.req = reqs[t];
      exp = model_pick(bus.req, model_ptr);
      exp_oh = '0; exp_oh[exp] = 1'b1;
      d = 8'($urandom);
      bus.m_data_out = d;
      follow_txn(-1);
      checks++; if (ft_timeout) begin errors++; $display("FAIL %s_timeout: txn %0d", name, t); end
      checks++; if (ft_gnt !== exp_oh) begin errors++; $display("FAIL %s_gnt: txn %0d got %b required %b", name, t, ft_gnt, exp_oh); end
      checks++;
      if ({ft_mode, ft_addr, ft_reg} !== {f_mode[exp], f_addr[exp], f_reg[exp]}) begin
        errors++;
        $display("FAIL %s_fields: txn %0d got %b/%h/%h required %b/%h/%h", name, t,
                 ft_mode, ft_addr, ft_reg, f_mode[exp], f_addr[exp], f_reg[exp]);
      end
      checks++; if (ft_done !== exp_oh) begin errors++; $display("FAIL %s_done: txn %0d got %b required %b", name, t, ft_done, exp_oh); end
      checks++; if (ft_rd !== d) begin errors++; $display("FAIL %s_rd_data: txn %0d got %h required %h", name, t, ft_rd, d); end
      if (chain && prev_abs >= 0) begin
        checks++;
        if (ft_done_abs - prev_abs !== LAT + 1) begin
          errors++; $display("FAIL %s_done_spacing: txn %0d got %0d required %0d", name, t, ft_done_abs - prev_abs, LAT + 1);
        end
      end
      prev_abs = ft_done_abs;
      model_ptr = ft_lock[exp] ? exp : (exp + 1) % N;
      rand_fields();
    end
    bus.req = '0;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] q [$];
    do_reset();
    rand_fields();
    q = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
    run_seq("rr_all", q, 1'b1);
  endtask

  task automatic test_ptr_skip();
    logic [N-1:0] q [$];
    do_reset();
    rand_fields();
    q = '{4'b0010, 4'b1010, 4'b0010};
    run_seq("ptr_skip", q, 1'b0);
  endtask

  task automatic test_random();
    logic [N-1:0] q [$];
    logic [N-1:0] r;
    do_reset();
    rand_fields();
    for (int t = 0; t < 10; t++) begin
      r = 4'($urandom);
      if (r == '0) r = 4'b0001 << $urandom_range(N - 1);
      q.push_back(r);
    end
    run_seq("random", q, 1'b0);
  endtask

  task automatic test_field_change();
    logic [6:0] a0;
    logic [7:0] r0;
    logic       m0;
    do_reset();
    rand_fields();
    a0 = f_addr[0]; r0 = f_reg[0]; m0 = f_mode[0];
    bus.m_data_out = 8'($urandom);
    bus.req = 4'b0001;
    follow_txn(20);
    model_ptr = 1;
    checks++;
    if ({ft_mode_end, ft_addr_end, ft_reg_end} !== {m0, a0, r0}) begin
      errors++;
      $display("FAIL field_hold: got %b/%h/%h required %b/%h/%h", ft_mode_end, ft_addr_end, ft_reg_end, m0, a0, r0);
    end
    checks++; if (ft_done !== 4'b0001) begin errors++; $display("FAIL field_drop_done: got %b required 0001", ft_done); end
    checks++; if (ft_done_c !== LAT) begin errors++; $display("FAIL field_drop_latency: got %0d required %0d", ft_done_c, LAT); end
    bus.req = '0;
    rand_fields();
  endtask

  task automatic test_reset_mid();
    int w;
    do_reset();
    rand_fields();
    bus.req = 4'b0001;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (bus.m_start !== 1'b1 && w < 20);
    checks++; if (bus.m_start !== 1'b1) begin errors++; $display("FAIL mid_reach_start: got %b required 1", bus.m_start); end
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    f_addr[0] = ~f_addr[0]; f_reg[0] = ~f_reg[0]; f_mode[0] = ~f_mode[0];
    set_fields();
    @(negedge clk);
    checks++;
    if ({bus.m_start, bus.m_stop, bus.m_en, bus.gnt, bus.done} !== '0) begin
      errors++;
      $display("FAIL mid_reset_abort: start=%b stop=%b en=%b gnt=%b done=%b required all 0",
               bus.m_start, bus.m_stop, bus.m_en, bus.gnt, bus.done);
    end
    reset_n = 1'b1;
    model_ptr = 0;
    bus.m_data_out = 8'($urandom);
    follow_txn(-1);
    checks++; if (ft_wait !== 1) begin errors++; $display("FAIL mid_regrant_delay: got %0d required 1", ft_wait); end
    checks++;
    if ({ft_mode, ft_addr, ft_reg} !== {f_mode[0], f_addr[0], f_reg[0]}) begin
      errors++; $display("FAIL mid_fresh_fields: got %h/%h required %h/%h", ft_addr, ft_reg, f_addr[0], f_reg[0]);
    end
    checks++; if (ft_done_c !== LAT || ft_done !== 4'b0001) begin
      errors++; $display("FAIL mid_restart_done: got %0d/%b required %0d/0001", ft_done_c, ft_done, LAT);
    end
    bus.req = '0;
  endtask

`ifdef I2C_ARB_LOCK_EN
  task automatic test_lock();
    int exp;
    logic [N-1:0] exp_oh;
    do_reset();
    rand_fields();
    bus.req_lock = 4'b0001;
    bus.req = 4'b0011;
    for (int t = 0; t < 3; t++) begin
      exp = model_pick(bus.req, model_ptr);
      exp_oh = '0; exp_oh[exp] = 1'b1;
      follow_txn(-1);
      checks++; if (ft_gnt !== exp_oh) begin errors++; $display("FAIL lock_gnt: txn %0d got %b required %b", t, ft_gnt, exp_oh); end
      checks++; if (ft_wait !== 1) begin errors++; $display("FAIL lock_back_to_back: txn %0d got %0d required 1", t, ft_wait); end
      model_ptr = ft_lock[exp] ? exp : (exp + 1) % N;
      bus.req_lock = '0;
    end
    bus.req = '0;
  endtask
`endif

  initial begin
    bus.req = '0; bus.req_mode = '0; bus.req_addr = '0; bus.req_reg = '0; bus.m_data_out = '0;
`ifdef I2C_ARB_LOCK_EN
    bus.req_lock = '0;
`endif
    model_ptr = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_skip();
    test_random();
    test_field_change();
    test_reset_mid();
`ifdef I2C_ARB_LOCK_EN
    test_lock();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
